yari_sram_ctrl: RTL and testbench

- Memory-side slave for the core's arbitrated memory port (id, address, read, write, data, mask, waitrequest, tagged readdata).
- Drives an external asynchronous 32-bit SRAM.
- Reads are cache-line bursts, returned critical-word-first with the requester's id.
- Writes are single words with byte masks.
- Sits directly downstream of the core top level; its outputs feed the core's mem_waitrequest, mem_readdata and mem_readdataid inputs.

---
 rtl/yari_sram_ctrl_pkg.sv | 25 ++
 rtl/yari_sram_ctrl_wait_counter.sv | 29 ++
 rtl/yari_sram_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_yari_sram_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/yari_sram_ctrl_pkg.sv
// Shared definitions for the SRAM memory-port controller: requester ids and FSM states.
// No logic; constants and a width helper only.
// A readdataid of ID_NONE means no data is on mem_readdata this cycle.
package yari_sram_ctrl_pkg;

  // Requester tags on the memory port. ID_NONE doubles as the "no data" marker.
  localparam logic [1:0] ID_NONE = 2'd0;
  localparam logic [1:0] ID_DC   = 2'd1;
  localparam logic [1:0] ID_IC   = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_R_ACC   = 3'd1,
    S_R_TURN  = 3'd2,
    S_W_SETUP = 3'd3,
    S_W_PULSE = 3'd4,
    S_W_HOLD  = 3'd5
  } state_t;

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/yari_sram_ctrl_wait_counter.sv
// Wait-state counter: loads a fixed count and runs down to zero; done is high at zero.
// Latency: done rises MAX cycles after load.
// No backpressure; load restarts the count at any time.
module yari_sram_ctrl_wait_counter #(
  parameter int MAX = 1,
  parameter int W   = 1
) (
  input  logic clock,
  input  logic rst,
  input  logic load,
  output logic done
);

  logic [W-1:0] cnt;

  // Load on access start, otherwise count down and park at zero.
  always_ff @(posedge clock) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= W'(MAX);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/yari_sram_ctrl.sv
// Async SRAM slave: critical-word-first read bursts tagged with id, masked single-word writes.
// Latency: read word k at T+1+(k+1)(WAIT_STATES+1); write occupies WAIT_STATES+4 cycles.
// Backpressure: mem_waitrequest is high whenever not IDLE or in reset; requester must hold.
module yari_sram_ctrl
  import yari_sram_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 18,
  parameter int WAIT_STATES = 1,
  parameter int BURST_LEN   = 4
) (
  input  logic              clock,
  input  logic              rst,
  output logic              mem_waitrequest,
  input  logic [1:0]        mem_id,
  input  logic [29:0]       mem_address,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       mem_writedata,
  input  logic [3:0]        mem_writedatamask,
  output logic [31:0]       mem_readdata,
  output logic [1:0]        mem_readdataid,
  output logic [ADDR_W-1:0] sram_a,
  output logic [31:0]       sram_d_out,
  output logic              sram_d_oe,
  input  logic [31:0]       sram_d_in,
  output logic              sram_cs_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [3:0]        sram_be_n
);

  localparam int WC_W   = cnt_width(WAIT_STATES + 1);
  localparam int BEAT_W = cnt_width(BURST_LEN);
  localparam logic [ADDR_W-1:0] LOW_MASK  = ADDR_W'(BURST_LEN - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  state_t              state, state_nxt;
  logic [BEAT_W-1:0]   beat, beat_nxt;
  logic [ADDR_W-1:0]   addr_q, addr_src;
  logic [1:0]          id_q;
  logic                accept, wc_load, wc_done, sample;
  logic [ADDR_W-1:0]   a_nxt;
  logic [31:0]         dout_nxt;
  logic [3:0]          be_nxt;
  logic                cs_nxt, oe_nxt, we_nxt, doe_nxt;
  logic                unused_addr;

  // Address bits above ADDR_W alias by design.
  assign unused_addr = ^mem_address;

  // Burst address: upper bits fixed, low field wraps inside the line.
  function automatic logic [ADDR_W-1:0] burst_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [BEAT_W-1:0] b);
    return (base & ~LOW_MASK) | ((base + ADDR_W'(b)) & LOW_MASK);
  endfunction

  assign mem_waitrequest = (state != S_IDLE) | ~rst;
  assign accept          = (state == S_IDLE) & (mem_read | mem_write);
  assign addr_src        = (state == S_IDLE) ? mem_address[ADDR_W-1:0] : addr_q;

  yari_sram_ctrl_wait_counter #(
    .MAX (WAIT_STATES),
    .W   (WC_W)
  ) u_wait (
    .clock (clock),
    .rst   (rst),
    .load  (wc_load),
    .done  (wc_done)
  );

  // Next state plus the pad values that state will present, so the pads are glitch-free flops.
  always_comb begin
    state_nxt = state;
    beat_nxt  = beat;
    wc_load   = 1'b0;
    sample    = 1'b0;
    a_nxt     = sram_a;
    dout_nxt  = sram_d_out;
    be_nxt    = 4'hF;
    cs_nxt    = 1'b1;
    oe_nxt    = 1'b1;
    we_nxt    = 1'b1;
    doe_nxt   = 1'b0;
    case (state)
      S_IDLE: begin
        // A write wins over a simultaneous read; the read is dropped.
        if (mem_write) begin
          state_nxt = S_W_SETUP;
        end else if (mem_read) begin
          state_nxt = S_R_ACC;
          beat_nxt  = '0;
          wc_load   = 1'b1;
        end
      end
      S_R_ACC: begin
        if (wc_done) begin
          sample   = 1'b1;
          wc_load  = 1'b1;
          beat_nxt = beat + 1'b1;
          if (beat == LAST_BEAT) state_nxt = S_R_TURN;
        end
      end
      S_R_TURN:  state_nxt = S_IDLE;
      S_W_SETUP: begin
        state_nxt = S_W_PULSE;
        wc_load   = 1'b1;
      end
      S_W_PULSE: if (wc_done) state_nxt = S_W_HOLD;
      S_W_HOLD:  state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
    case (state_nxt)
      S_R_ACC: begin
        cs_nxt = 1'b0;
        oe_nxt = 1'b0;
        be_nxt = 4'h0;
        a_nxt  = burst_addr(addr_src, beat_nxt);
      end
      S_W_SETUP: begin
        cs_nxt   = 1'b0;
        doe_nxt  = 1'b1;
        be_nxt   = ~mem_writedatamask;
        a_nxt    = addr_src;
        dout_nxt = mem_writedata;
      end
      S_W_PULSE: begin
        cs_nxt  = 1'b0;
        we_nxt  = 1'b0;
        doe_nxt = 1'b1;
        be_nxt  = sram_be_n;
      end
      S_W_HOLD: begin
        cs_nxt  = 1'b0;
        doe_nxt = 1'b1;
        be_nxt  = sram_be_n;
      end
      default: ;
    endcase
  end

  // FSM state, beat index and request latches.
  always_ff @(posedge clock) begin
    if (!rst) begin
      state  <= S_IDLE;
      beat   <= '0;
      addr_q <= '0;
      id_q   <= ID_NONE;
    end else begin
      state <= state_nxt;
      beat  <= beat_nxt;
      if (accept) begin
        addr_q <= mem_address[ADDR_W-1:0];
        id_q   <= mem_id;
      end
    end
  end

  // Registered SRAM pad controls; reset forces all strobes inactive on the next cycle.
  always_ff @(posedge clock) begin
    if (!rst) begin
      sram_a     <= '0;
      sram_d_out <= '0;
      sram_d_oe  <= 1'b0;
      sram_cs_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_be_n  <= 4'hF;
    end else begin
      sram_a     <= a_nxt;
      sram_d_out <= dout_nxt;
      sram_d_oe  <= doe_nxt;
      sram_cs_n  <= cs_nxt;
      sram_oe_n  <= oe_nxt;
      sram_we_n  <= we_nxt;
      sram_be_n  <= be_nxt;
    end
  end

  // Return path: one-cycle tagged word after the final cycle of each beat.
  always_ff @(posedge clock) begin
    if (!rst) begin
      mem_readdata   <= '0;
      mem_readdataid <= ID_NONE;
    end else begin
      mem_readdataid <= sample ? id_q : ID_NONE;
      if (sample) mem_readdata <= sram_d_in;
    end
  end

`ifndef SYNTHESIS
  // Flag requesters that assert read and write together.
  always_ff @(posedge clock) begin
    if (rst && state == S_IDLE && mem_read && mem_write)
      $warning("yari_sram_ctrl: read and write asserted together, read dropped");
  end
`endif

endmodule

// File: tb/tb_yari_sram_ctrl.sv
module tb_yari_sram_ctrl;

  localparam int WS0 = 1;
  localparam int BL0 = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic rst;

  // DUT 0: WAIT_STATES=1, BURST_LEN=4
  logic        wreq0, rd0, wr0, sdoe0, cs0_n, oe0_n, we0_n;
  logic [1:0]  id0, rdid0;
  logic [29:0] addr0;
  logic [31:0] wdata0, rdata0, sdo0, sdi0;
  logic [3:0]  wmask0, be0_n;
  logic [17:0] sa0;

  // DUT 1: WAIT_STATES=0, BURST_LEN=1
  logic        wreq1, rd1, sdoe1, cs1_n, oe1_n, we1_n;
  logic [1:0]  id1, rdid1;
  logic [29:0] addr1;
  logic [31:0] rdata1, sdo1, sdi1;
  logic [3:0]  be1_n;
  logic [17:0] sa1;

  yari_sram_ctrl #(.ADDR_W(18), .WAIT_STATES(WS0), .BURST_LEN(BL0)) dut0 (
    .clock(clock), .rst(rst), .mem_waitrequest(wreq0), .mem_id(id0),
    .mem_address(addr0), .mem_read(rd0), .mem_write(wr0),
    .mem_writedata(wdata0), .mem_writedatamask(wmask0),
    .mem_readdata(rdata0), .mem_readdataid(rdid0),
    .sram_a(sa0), .sram_d_out(sdo0), .sram_d_oe(sdoe0), .sram_d_in(sdi0),
    .sram_cs_n(cs0_n), .sram_oe_n(oe0_n), .sram_we_n(we0_n), .sram_be_n(be0_n));

  yari_sram_ctrl #(.ADDR_W(18), .WAIT_STATES(0), .BURST_LEN(1)) dut1 (
    .clock(clock), .rst(rst), .mem_waitrequest(wreq1), .mem_id(id1),
    .mem_address(addr1), .mem_read(rd1), .mem_write(1'b0),
    .mem_writedata(32'h0), .mem_writedatamask(4'h0),
    .mem_readdata(rdata1), .mem_readdataid(rdid1),
    .sram_a(sa1), .sram_d_out(sdo1), .sram_d_oe(sdoe1), .sram_d_in(sdi1),
    .sram_cs_n(cs1_n), .sram_oe_n(oe1_n), .sram_we_n(we1_n), .sram_be_n(be1_n));

  // Async SRAM models
  logic [31:0] sram0 [256];
  logic        preload;
  assign sdi0 = (!cs0_n && !oe0_n) ? sram0[sa0[7:0]] : 32'hDEAD_BEEF;
  assign sdi1 = (!cs1_n && !oe1_n) ? (32'h2000 + 32'(sa1)) : 32'hDEAD_BEEF;

  always @(posedge clock) begin
    if (preload) begin
      for (int n = 0; n < 256; n++) sram0[n] = 32'h1000 + n;
      sram0[8'h10] = 32'h1122_3344;
    end else if (!cs0_n && !we0_n) begin
      for (int b = 0; b < 4; b++)
        if (!be0_n[b]) sram0[sa0[7:0]][8*b +: 8] = sdo0[8*b +: 8];
    end
  end

  // Behavioural model of DUT 0: reference memory, expected tagged words per cycle, busy window.
  logic [31:0] ref0 [256];
  logic [1:0]  exp_id  [int];
  logic [31:0] exp_dat [int];
  int busy_lo = -1;
  int busy_hi = -2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison of DUT 0 against the model, plus the pad-direction invariant.
  logic prev_oe_n = 1'b1;
  always @(negedge clock) begin
    if (cyc >= 1) begin
      logic [1:0] eid;
      eid = exp_id.exists(cyc) ? exp_id[cyc] : 2'd0;
      check("model_waitrequest", {31'b0, wreq0},
            {31'b0, (!rst) || (cyc >= busy_lo && cyc <= busy_hi)});
      check("model_readdataid", {30'b0, rdid0}, {30'b0, eid});
      if (eid != 2'd0) check("model_readdata", rdata0, exp_dat[cyc]);
      check("doe_vs_oe_n", {31'b0, sdoe0 & (~oe0_n | ~prev_oe_n)}, 32'd0);
      prev_oe_n = oe0_n;
    end
  end

  task automatic at_cycle(input int c);
    while (cyc < c) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_idle0(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clock);
      #1;
      if (!wreq0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_idle timeout at cycle %0d: waitrequest stuck at 1, expected 0", cyc);
    end
  endtask

  task automatic issue_read(input logic [1:0] id, input int addr, output int t);
    bit ok;
    wait_idle0(ok);
    t = -100;
    if (ok) begin
      t = cyc;
      id0 = id; addr0 = 30'(addr); rd0 = 1'b1;
      for (int k = 0; k < BL0; k++) begin
        int w, c;
        w = (addr & ~(BL0 - 1)) | ((addr + k) & (BL0 - 1));
        c = t + 1 + (k + 1) * (WS0 + 1);
        if (id != 2'd0) begin
          exp_id[c]  = id;
          exp_dat[c] = ref0[w & 255];
        end
      end
      busy_lo = t + 1;
      busy_hi = t + BL0 * (WS0 + 1) + 1;
      @(posedge clock);
      #1;
      rd0 = 1'b0; id0 = 2'd0;
    end
  endtask

  task automatic issue_write(input int addr, input logic [31:0] d, input logic [3:0] m,
                             input bit also_read, output int t);
    bit ok;
    wait_idle0(ok);
    t = -100;
    if (ok) begin
      t = cyc;
      id0 = 2'd1; addr0 = 30'(addr); wdata0 = d; wmask0 = m; wr0 = 1'b1; rd0 = also_read;
      for (int b = 0; b < 4; b++)
        if (m[b]) ref0[addr & 255][8*b +: 8] = d[8*b +: 8];
      busy_lo = t + 1;
      busy_hi = t + WS0 + 3;
      @(posedge clock);
      #1;
      wr0 = 1'b0; rd0 = 1'b0; id0 = 2'd0;
    end
  endtask

  initial begin
    int t, tw;
    int kill[$];
    rst = 1'b0; preload = 1'b1;
    rd0 = 0; wr0 = 0; id0 = 0; addr0 = 0; wdata0 = 0; wmask0 = 0;
    rd1 = 0; id1 = 0; addr1 = 0;
    for (int n = 0; n < 256; n++) ref0[n] = 32'h1000 + n;
    ref0[8'h10] = 32'h1122_3344;

    // Reset state
    at_cycle(1);
    check("rst_readdataid", {30'b0, rdid0}, 32'd0);
    check("rst_readdata", rdata0, 32'd0);
    check("rst_sram_a", {14'b0, sa0}, 32'd0);
    check("rst_strobes", {28'b0, cs0_n, oe0_n, we0_n, sdoe0}, 32'b1110);
    check("rst_be_n", {28'b0, be0_n}, 32'hF);
    check("rst_waitrequest", {31'b0, wreq0}, 32'd1);
    at_cycle(3);
    rst = 1'b1; preload = 1'b0;

    // Critical-word-first burst from 0x06, then a write straight after it
    issue_read(2'd2, 32'h06, t);
    at_cycle(t + 3); check("t1_w0", rdata0, 32'h1006); check("t1_id", {30'b0, rdid0}, 32'd2);
    at_cycle(t + 5); check("t1_w1", rdata0, 32'h1007);
    at_cycle(t + 7); check("t1_w2", rdata0, 32'h1004);
    at_cycle(t + 9); check("t1_w3", rdata0, 32'h1005);
    check("t3_turn_strobes", {30'b0, cs0_n, oe0_n}, 32'b11);
    issue_write(32'h40, 32'h5566_7788, 4'hF, 1'b0, tw);
    check("t3_gap", 32'(tw), 32'(t + 10));
    at_cycle(tw + 1); check("t3_setup_doe", {31'b0, sdoe0}, 32'd1);

    // Masked write over 0x11223344, then read it back
    issue_write(32'h10, 32'hAABB_CCDD, 4'b0101, 1'b0, t);
    at_cycle(t + 1); check("t2_be_n", {28'b0, be0_n}, 32'b1010);
    check("t2_we_setup", {31'b0, we0_n}, 32'd1);
    at_cycle(t + 2); check("t2_we_p0", {31'b0, we0_n}, 32'd0);
    at_cycle(t + 3); check("t2_we_p1", {31'b0, we0_n}, 32'd0);
    at_cycle(t + 4); check("t2_we_hold", {31'b0, we0_n}, 32'd1);
    at_cycle(t + 5); check("t2_wreq_low", {31'b0, wreq0}, 32'd0);
    issue_read(2'd1, 32'h10, t);
    at_cycle(t + 3); check("t2_readback", rdata0, 32'h11BB_33DD);

    // Read with id 0 runs but returns no visible data
    issue_read(2'd0, 32'h08, t);
    at_cycle(t + 3); check("id0_invisible", {30'b0, rdid0}, 32'd0);

    // Empty mask: full write timing, no byte changes
    issue_write(32'h21, 32'hFFFF_FFFF, 4'h0, 1'b0, t);
    at_cycle(t + 2); check("mask0_be_n", {28'b0, be0_n}, 32'hF);

    // Read and write together: write wins
    issue_write(32'h20, 32'hCAFE_F00D, 4'hF, 1'b1, t);
    issue_read(2'd1, 32'h20, t);
    at_cycle(t + 3); check("t6_readback", rdata0, 32'hCAFE_F00D);
    issue_read(2'd1, 32'h21, t);
    at_cycle(t + 3); check("mask0_unchanged", rdata0, 32'h1021);

    // Reset in the middle of a burst after two beats
    issue_read(2'd2, 32'h04, t);
    at_cycle(t + 6);
    rst = 1'b0;
    kill.delete();
    foreach (exp_id[k]) if (k > cyc) kill.push_back(k);
    foreach (kill[i]) begin
      exp_id.delete(kill[i]);
      exp_dat.delete(kill[i]);
    end
    busy_hi = cyc;
    at_cycle(t + 7);
    check("t4_cs_n", {31'b0, cs0_n}, 32'd1);
    check("t4_wreq_rst", {31'b0, wreq0}, 32'd1);
    at_cycle(t + 8);
    rst = 1'b1;
    at_cycle(t + 9); check("t4_wreq_after", {31'b0, wreq0}, 32'd0);
    issue_read(2'd2, 32'h05, t);
    at_cycle(t + 3); check("t4_new_read", rdata0, 32'h1005);
    at_cycle(t + 12);

    // Single-word, zero-wait-state instance
    t = cyc;
    check("t5_wreq_idle", {31'b0, wreq1}, 32'd0);
    id1 = 2'd1; addr1 = 30'h33; rd1 = 1'b1;
    at_cycle(t + 1);
    rd1 = 1'b0; id1 = 2'd0;
    check("t5_wreq_busy", {31'b0, wreq1}, 32'd1);
    check("t5_noid_early", {30'b0, rdid1}, 32'd0);
    at_cycle(t + 2);
    check("t5_id", {30'b0, rdid1}, 32'd1);
    check("t5_data", rdata1, 32'h2033);
    check("t5_wreq_turn", {31'b0, wreq1}, 32'd1);
    at_cycle(t + 3);
    check("t5_wreq_low", {31'b0, wreq1}, 32'd0);
    check("t5_noid_late", {30'b0, rdid1}, 32'd0);

    @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
